// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue controller for the decode stage: tracks in-flight
// register writes, stalls on RAW/WAW hazards and sequences drains for serialising instructions.
module reg_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wen,
  input  logic        id_serial,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        id_stall,
  output logic        id_issue,
  output logic [31:0] busy_vec,
  output logic        drain_done,
  output logic        sb_err
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Entry 0 exists only so the array can be indexed directly; it never leaves zero.
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [31:0]      busy_d;
  logic [31:0]      inc_vec;
  logic [31:0]      wb_hit;
  logic             err_d;
  logic             all_idle;

  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rs1_byp;
  logic             rs2_byp;
  logic             rs1_haz;
  logic             rs2_haz;
  logic             rd_haz;

  assign rs1_cnt = cnt_q[id_rs1];
  assign rs2_cnt = cnt_q[id_rs2];
  assign rd_cnt  = cnt_q[id_rd];

  // Forwarding covers a source only when the retiring write is its last one outstanding.
  assign rs1_byp = WB_BYPASS && wb_valid && (wb_rd == id_rs1) && (rs1_cnt == CNT_ONE);
  assign rs2_byp = WB_BYPASS && wb_valid && (wb_rd == id_rs2) && (rs2_cnt == CNT_ONE);

  assign rs1_haz = id_use_rs1 && (id_rs1 != 5'd0) && (rs1_cnt != CNT_ZERO) && !rs1_byp;
  assign rs2_haz = id_use_rs2 && (id_rs2 != 5'd0) && (rs2_cnt != CNT_ZERO) && !rs2_byp;
  assign rd_haz  = id_wen && (id_rd != 5'd0) && (rd_cnt == CNT_MAX);

  always_comb begin
    all_idle = 1'b1;
    for (int r = 1; r < 32; r++) begin
      if (cnt_q[r] != CNT_ZERO) all_idle = 1'b0;
    end
  end

  assign id_stall = id_valid && (rs1_haz || rs2_haz || rd_haz || (state_q != ST_RUN) ||
                                 (id_serial && !all_idle));
  assign id_issue = id_valid && !id_stall;

  // NOTE: every always_comb output gets a default before any conditional write,
  // otherwise paths that skip the assignment infer latches.
  always_comb begin
    inc_vec = '0;
    wb_hit  = '0;
    if (id_issue && id_wen) inc_vec[id_rd] = 1'b1;
    if (wb_valid)           wb_hit[wb_rd]  = 1'b1;
    inc_vec[0] = 1'b0;
    wb_hit[0]  = 1'b0;
  end

  always_comb begin
    err_d = sb_err;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r]  = cnt_q[r];
      busy_d[r] = 1'b0;
    end
    for (int r = 1; r < 32; r++) begin
      if (wb_hit[r] && (cnt_q[r] == CNT_ZERO)) begin
        err_d = 1'b1;
        if (inc_vec[r]) cnt_d[r] = CNT_ONE;
      end else if (inc_vec[r] && !wb_hit[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (wb_hit[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
      busy_d[r] = (cnt_d[r] != CNT_ZERO);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (id_valid && id_serial && !all_idle) state_d = ST_DRAIN;
      ST_DRAIN: if (all_idle) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      busy_vec   <= '0;
      drain_done <= 1'b0;
      sb_err     <= 1'b0;
      // NOTE: the counter array is reset explicitly; it is scoreboard state, not
      // storage, and stale counts after reset would stall decode forever.
      for (int r = 0; r < 32; r++) cnt_q[r] <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      busy_vec   <= busy_d;
      drain_done <= (state_d == ST_DONE);
      sb_err     <= err_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule
